// File: rtl/calc_sequencer_if.sv
// Control/status bundle between the ratio-times-sine datapath and its sequencer.
// The master side drives requests and datapath status; the slave side is the sequencer.
interface calc_sequencer_if;
  logic       start;
  logic       divisor_zero;
  logic       div_ok;
  logic       busy;
  logic       ld_en;
  logic       div_en;
  logic       s2p_en;
  logic [3:0] ser_cnt;
  logic       mul_en;
  logic       y_ld;
  logic       done;
  logic       err;

  modport master (
    output start,
    output divisor_zero,
    output div_ok,
    input  busy,
    input  ld_en,
    input  div_en,
    input  s2p_en,
    input  ser_cnt,
    input  mul_en,
    input  y_ld,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  divisor_zero,
    input  div_ok,
    output busy,
    output ld_en,
    output div_en,
    output s2p_en,
    output ser_cnt,
    output mul_en,
    output y_ld,
    output done,
    output err
  );
endinterface

// File: rtl/calc_sequencer.sv
// Sequencer for the ratio-times-sine datapath: load, divide + serial capture, multiply, store.
// One Moore FSM with run/serial/multiply counters and a sticky error flag.
module calc_sequencer #(
  parameter int unsigned SER_BITS    = 10,
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  calc_sequencer_if.slave bus
);

  localparam logic [3:0] SerBits = 4'(SER_BITS);
  localparam logic [3:0] SerLast = 4'(SER_BITS - 1);
  localparam logic [3:0] MulLast = 4'(MUL_LAT - 1);
  localparam logic [7:0] RunLast = 8'(DIV_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StMul,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ser_cnt_q, ser_cnt_d;
  logic [7:0] run_cnt_q, run_cnt_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       div_seen_q, div_seen_d;
  logic       err_q, err_d;

  logic busy, ld_en, div_en, s2p_en, mul_en, y_ld, done;
  logic accept, clear, div_done, ser_done, zero_err, timeout_err, run_err;

  assign accept   = (state_q == StIdle) && bus.start;
  // Clearing at the accept edge as well as in LOAD makes err/ser_cnt read 0 during LOAD.
  assign clear    = accept || (state_q == StLoad);
  assign div_done = div_seen_q || bus.div_ok;
  assign ser_done = (ser_cnt_q == SerBits) || (s2p_en && (ser_cnt_q == SerLast));

  assign zero_err    = (run_cnt_q == 8'd0) && bus.divisor_zero;
  assign timeout_err = (run_cnt_q == RunLast) && !div_done;
  assign run_err     = zero_err || timeout_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: state_d = StRun;
      StRun: begin
        if (run_err) begin
          state_d = StDone;
        end else if (div_done && ser_done) begin
          state_d = StMul;
        end
      end
      StMul: begin
        if (mul_cnt_q == MulLast) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy   = 1'b1;
    ld_en  = 1'b0;
    div_en = 1'b0;
    s2p_en = 1'b0;
    mul_en = 1'b0;
    y_ld   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StLoad: ld_en = 1'b1;
      StRun: begin
        div_en = 1'b1;
        s2p_en = (ser_cnt_q < SerBits);
      end
      StMul: mul_en = 1'b1;
      StDone: begin
        y_ld = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Counters and flags
  always_comb begin
    ser_cnt_d  = ser_cnt_q;
    run_cnt_d  = run_cnt_q;
    div_seen_d = div_seen_q;
    err_d      = err_q;
    mul_cnt_d  = 4'd0;
    if (clear) begin
      ser_cnt_d  = 4'd0;
      run_cnt_d  = 8'd0;
      div_seen_d = 1'b0;
      err_d      = 1'b0;
    end else if (state_q == StRun) begin
      run_cnt_d = run_cnt_q + 8'd1;
      if (s2p_en) ser_cnt_d = ser_cnt_q + 4'd1;
      if (bus.div_ok) div_seen_d = 1'b1;
      if (run_err) err_d = 1'b1;
    end else if (state_q == StMul) begin
      mul_cnt_d = mul_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ser_cnt_q  <= 4'd0;
      run_cnt_q  <= 8'd0;
      mul_cnt_q  <= 4'd0;
      div_seen_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ser_cnt_q  <= ser_cnt_d;
      run_cnt_q  <= run_cnt_d;
      mul_cnt_q  <= mul_cnt_d;
      div_seen_q <= div_seen_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy    = busy;
  assign bus.ld_en   = ld_en;
  assign bus.div_en  = div_en;
  assign bus.s2p_en  = s2p_en;
  assign bus.ser_cnt = ser_cnt_q;
  assign bus.mul_en  = mul_en;
  assign bus.y_ld    = y_ld;
  assign bus.done    = done;
  assign bus.err     = err_q;

endmodule
